ddr_multi_ring_sequencer: RTL and testbench

//  Burst-descriptor sequencer for NUM_CH independent DDR ring buffers sharing one AXI master.

---
 rtl/ddr_multi_ring_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_ddr_multi_ring_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_multi_ring_sequencer.sv
// Burst-descriptor sequencer for NUM_CH DDR ring buffers sharing one AXI master.
// Round-robin AW/AR descriptor arbitration with per-channel slot pointers, fill counts and sticky flags.
module ddr_multi_ring_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int BURST_LEN      = 128,
  parameter int SLOT_W         = 16,
  parameter int DROP_MODE      = 0,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH*AXI_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [NUM_CH*SLOT_W-1:0]         cfg_slots,
  input  logic [NUM_CH-1:0]                cfg_enable,
  input  logic [NUM_CH-1:0]                soft_clr,
  input  logic [NUM_CH-1:0]                wr_req,
  input  logic [NUM_CH-1:0]                rd_req,
  output logic [NUM_CH-1:0]                wr_gnt,
  output logic [NUM_CH-1:0]                rd_gnt,
  output logic                             wr_drop,
  output logic                             aw_desc_valid,
  input  logic                             aw_desc_ready,
  output logic [AXI_ADDR_WIDTH-1:0]        aw_desc_addr,
  output logic [CH_W-1:0]                  aw_desc_ch,
  output logic                             ar_desc_valid,
  input  logic                             ar_desc_ready,
  output logic [AXI_ADDR_WIDTH-1:0]        ar_desc_addr,
  output logic [CH_W-1:0]                  ar_desc_ch,
  input  logic                             wr_done,
  input  logic [CH_W-1:0]                  wr_done_ch,
  input  logic                             rd_done,
  input  logic [CH_W-1:0]                  rd_done_ch,
  output logic [NUM_CH*SLOT_W-1:0]         ch_fill,
  output logic [NUM_CH-1:0]                ch_full,
  output logic [NUM_CH-1:0]                ch_empty,
  output logic [NUM_CH-1:0]                data_loss,
  input  logic [NUM_CH-1:0]                clear_eob,
  output logic [NUM_CH-1:0]                eob
);

  localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);

  logic [SLOT_W-1:0]         wslot     [NUM_CH];
  logic [SLOT_W-1:0]         rslot     [NUM_CH];
  logic [SLOT_W-1:0]         cslot     [NUM_CH];
  logic [SLOT_W-1:0]         alloc     [NUM_CH];
  logic [SLOT_W-1:0]         committed [NUM_CH];
  logic [SLOT_W-1:0]         slots     [NUM_CH];
  logic [AXI_ADDR_WIDTH-1:0] base      [NUM_CH];

  logic [NUM_CH-1:0] wr_elig, rd_elig;
  logic [NUM_CH-1:0] wr_adv, wr_lost, rd_adv, wdone, rdone, eob_set;
  logic [CH_W-1:0]   aw_rr, ar_rr;
  logic [CH_W-1:0]   aw_sel_p0, ar_sel_p0;
  logic              aw_found_p0, ar_found_p0;
  logic              aw_take_p0, ar_take_p0;
  logic              aw_fire_p0, ar_fire_p0, aw_drop_p0;

  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s,
                                                 input logic [SLOT_W-1:0] n);
    return (s == n - SLOT_W'(1)) ? '0 : s + SLOT_W'(1);
  endfunction

  function automatic logic [AXI_ADDR_WIDTH-1:0] slot_addr(input logic [AXI_ADDR_WIDTH-1:0] b,
                                                          input logic [SLOT_W-1:0] s);
    return b + AXI_ADDR_WIDTH'(s) * BURST_BYTES;
  endfunction

  // Returns {found, channel}: first eligible channel at or after ptr, wrapping.
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] elig,
                                            input logic [CH_W-1:0] ptr);
    logic            found;
    logic [CH_W-1:0] sel;
    int              idx;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] s);
    return (int'(s) == NUM_CH - 1) ? '0 : s + CH_W'(1);
  endfunction

  always_comb begin
    wr_elig = '0;
    rd_elig = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      slots[c] = cfg_slots[c*SLOT_W +: SLOT_W];
      base[c]  = cfg_base_addr[c*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      // A channel being soft-cleared this cycle is not offered to the arbiters.
      wr_elig[c] = wr_req[c] & cfg_enable[c] & ~soft_clr[c] & (slots[c] != '0) &
                   ((alloc[c] < slots[c]) | (DROP_MODE != 0));
      rd_elig[c] = rd_req[c] & cfg_enable[c] & ~soft_clr[c] & (committed[c] != '0);
    end
  end

  // Stage p0: arbitration decision, registered into descriptor/grant outputs.
  assign {aw_found_p0, aw_sel_p0} = rr_pick(wr_elig, aw_rr);
  assign {ar_found_p0, ar_sel_p0} = rr_pick(rd_elig, ar_rr);
  assign aw_take_p0 = ~aw_desc_valid | aw_desc_ready;
  assign ar_take_p0 = ~ar_desc_valid | ar_desc_ready;
  assign aw_fire_p0 = aw_take_p0 & aw_found_p0;
  assign ar_fire_p0 = ar_take_p0 & ar_found_p0;
  assign aw_drop_p0 = aw_fire_p0 & (DROP_MODE != 0) & (alloc[aw_sel_p0] >= slots[aw_sel_p0]);

  always_comb begin
    wr_adv  = '0;
    wr_lost = '0;
    rd_adv  = '0;
    wdone   = '0;
    rdone   = '0;
    eob_set = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_adv[c]  = aw_fire_p0 & ~aw_drop_p0 & (aw_sel_p0 == CH_W'(c));
      wr_lost[c] = aw_fire_p0 & aw_drop_p0 & (aw_sel_p0 == CH_W'(c));
      rd_adv[c]  = ar_fire_p0 & (ar_sel_p0 == CH_W'(c));
      wdone[c]   = wr_done & (wr_done_ch == CH_W'(c)) & (alloc[c] != '0);
      rdone[c]   = rd_done & (rd_done_ch == CH_W'(c)) & (alloc[c] != '0);
      eob_set[c] = wdone[c] & (cslot[c] == slots[c] - SLOT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_desc_valid <= 1'b0;
      aw_desc_addr  <= '0;
      aw_desc_ch    <= '0;
      wr_gnt        <= '0;
      wr_drop       <= 1'b0;
      aw_rr         <= '0;
    end else begin
      wr_gnt  <= '0;
      wr_drop <= 1'b0;
      if (aw_take_p0) aw_desc_valid <= aw_fire_p0 & ~aw_drop_p0;
      if (aw_fire_p0) begin
        wr_gnt  <= NUM_CH'(1) << aw_sel_p0;
        wr_drop <= aw_drop_p0;
        aw_rr   <= rr_next(aw_sel_p0);
        if (!aw_drop_p0) begin
          aw_desc_addr <= slot_addr(base[aw_sel_p0], wslot[aw_sel_p0]);
          aw_desc_ch   <= aw_sel_p0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_desc_valid <= 1'b0;
      ar_desc_addr  <= '0;
      ar_desc_ch    <= '0;
      rd_gnt        <= '0;
      ar_rr         <= '0;
    end else begin
      rd_gnt <= '0;
      if (ar_take_p0) ar_desc_valid <= ar_fire_p0;
      if (ar_fire_p0) begin
        rd_gnt       <= NUM_CH'(1) << ar_sel_p0;
        ar_rr        <= rr_next(ar_sel_p0);
        ar_desc_addr <= slot_addr(base[ar_sel_p0], rslot[ar_sel_p0]);
        ar_desc_ch   <= ar_sel_p0;
      end
    end
  end

  // Per-channel ring state; grant and DONE on the same cycle combine arithmetically.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wslot[c]     <= '0;
        rslot[c]     <= '0;
        cslot[c]     <= '0;
        alloc[c]     <= '0;
        committed[c] <= '0;
      end
      data_loss <= '0;
      eob       <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (soft_clr[c]) begin
          wslot[c]     <= '0;
          rslot[c]     <= '0;
          cslot[c]     <= '0;
          alloc[c]     <= '0;
          committed[c] <= '0;
          data_loss[c] <= 1'b0;
          eob[c]       <= 1'b0;
        end else begin
          if (wr_adv[c]) wslot[c] <= slot_inc(wslot[c], slots[c]);
          if (rd_adv[c]) rslot[c] <= slot_inc(rslot[c], slots[c]);
          if (wdone[c])  cslot[c] <= slot_inc(cslot[c], slots[c]);
          alloc[c]     <= alloc[c] + SLOT_W'(wr_adv[c]) - SLOT_W'(rdone[c]);
          committed[c] <= committed[c] + SLOT_W'(wdone[c]) - SLOT_W'(rd_adv[c]);
          if (wr_lost[c]) data_loss[c] <= 1'b1;
          if (clear_eob[c])    eob[c] <= 1'b0;
          else if (eob_set[c]) eob[c] <= 1'b1;
        end
      end
    end
  end

  // A channel with no slots configured never reports full.
  always_comb begin
    ch_fill  = '0;
    ch_full  = '0;
    ch_empty = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_fill[c*SLOT_W +: SLOT_W] = alloc[c];
      ch_full[c]  = (slots[c] != '0) & (alloc[c] == slots[c]);
      ch_empty[c] = (committed[c] == '0);
    end
  end

endmodule

// File: tb/tb_ddr_multi_ring_sequencer.sv
// Bench for ddr_multi_ring_sequencer: directed scenarios plus randomized traffic against a
// counter-based reference model; a second instance with DROP_MODE=1 covers the drop path.
module tb_ddr_multi_ring_sequencer;

  localparam logic [31:0] BASE [4] = '{32'h0000_1000, 32'h0000_8000, 32'hFFFF_F800, 32'h0000_2000};
  localparam int SLOTS [4] = '{4, 3, 5, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  logic [127:0] cfg_base_addr;
  logic [63:0]  cfg_slots, ch_fill;
  logic [3:0]   cfg_enable, soft_clr, wr_req, rd_req, clear_eob;
  logic [3:0]   wr_gnt, rd_gnt, ch_full, ch_empty, data_loss, eob;
  logic         wr_drop, aw_desc_valid, aw_desc_ready, ar_desc_valid, ar_desc_ready;
  logic [31:0]  aw_desc_addr, ar_desc_addr;
  logic [1:0]   aw_desc_ch, ar_desc_ch, wr_done_ch, rd_done_ch;
  logic         wr_done, rd_done;

  logic [127:0] d_cfg_base_addr;
  logic [63:0]  d_cfg_slots, d_ch_fill;
  logic [3:0]   d_cfg_enable, d_soft_clr, d_wr_req, d_rd_req, d_clear_eob;
  logic [3:0]   d_wr_gnt, d_rd_gnt, d_ch_full, d_ch_empty, d_data_loss, d_eob;
  logic         d_wr_drop, d_aw_valid, d_aw_ready, d_ar_valid, d_ar_ready;
  logic [31:0]  d_aw_addr, d_ar_addr;
  logic [1:0]   d_aw_ch, d_ar_ch, d_wr_done_ch, d_rd_done_ch;
  logic         d_wr_done, d_rd_done;

  ddr_multi_ring_sequencer #(.NUM_CH(4), .DROP_MODE(0)) dut (
    .clk(clk), .rst(rst), .cfg_base_addr(cfg_base_addr), .cfg_slots(cfg_slots),
    .cfg_enable(cfg_enable), .soft_clr(soft_clr), .wr_req(wr_req), .rd_req(rd_req),
    .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .wr_drop(wr_drop),
    .aw_desc_valid(aw_desc_valid), .aw_desc_ready(aw_desc_ready),
    .aw_desc_addr(aw_desc_addr), .aw_desc_ch(aw_desc_ch),
    .ar_desc_valid(ar_desc_valid), .ar_desc_ready(ar_desc_ready),
    .ar_desc_addr(ar_desc_addr), .ar_desc_ch(ar_desc_ch),
    .wr_done(wr_done), .wr_done_ch(wr_done_ch), .rd_done(rd_done), .rd_done_ch(rd_done_ch),
    .ch_fill(ch_fill), .ch_full(ch_full), .ch_empty(ch_empty), .data_loss(data_loss),
    .clear_eob(clear_eob), .eob(eob));

  ddr_multi_ring_sequencer #(.NUM_CH(4), .DROP_MODE(1)) dut_drop (
    .clk(clk), .rst(rst), .cfg_base_addr(d_cfg_base_addr), .cfg_slots(d_cfg_slots),
    .cfg_enable(d_cfg_enable), .soft_clr(d_soft_clr), .wr_req(d_wr_req), .rd_req(d_rd_req),
    .wr_gnt(d_wr_gnt), .rd_gnt(d_rd_gnt), .wr_drop(d_wr_drop),
    .aw_desc_valid(d_aw_valid), .aw_desc_ready(d_aw_ready),
    .aw_desc_addr(d_aw_addr), .aw_desc_ch(d_aw_ch),
    .ar_desc_valid(d_ar_valid), .ar_desc_ready(d_ar_ready),
    .ar_desc_addr(d_ar_addr), .ar_desc_ch(d_ar_ch),
    .wr_done(d_wr_done), .wr_done_ch(d_wr_done_ch), .rd_done(d_rd_done), .rd_done_ch(d_rd_done_ch),
    .ch_fill(d_ch_fill), .ch_full(d_ch_full), .ch_empty(d_ch_empty), .data_loss(d_data_loss),
    .clear_eob(d_clear_eob), .eob(d_eob));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: ring pointers are lifetime event counts taken modulo the ring length.
  int nwr [4], nfree [4], ncom [4], nrd [4];
  logic [3:0]  m_eob, m_wg, m_rg;
  logic        m_awv, m_arv;
  logic [31:0] m_awa, m_ara;
  int          m_awc, m_arc, m_rrw, m_rrr;
  int          wq [$], rq [$];
  bit          model_on = 0;

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      nwr[c] = 0; nfree[c] = 0; ncom[c] = 0; nrd[c] = 0;
    end
    m_eob = '0; m_wg = '0; m_rg = '0; m_awv = 0; m_arv = 0;
    m_awa = '0; m_ara = '0; m_awc = 0; m_arc = 0; m_rrw = 0; m_rrr = 0;
    wq.delete(); rq.delete();
  endtask

  task automatic model_clock();
    int  ws, rs, c;
    bit  wf, rf, wtake, rtake;
    if (m_awv && aw_desc_ready) wq.push_back(m_awc);
    if (m_arv && ar_desc_ready) rq.push_back(m_arc);
    wtake = !m_awv || aw_desc_ready;
    rtake = !m_arv || ar_desc_ready;
    wf = 0; rf = 0; ws = 0; rs = 0;
    for (int k = 0; k < 4; k++) begin
      c = (m_rrw + k) % 4;
      if (!wf && wr_req[c] && cfg_enable[c] && !soft_clr[c] && SLOTS[c] != 0 &&
          (nwr[c] - nfree[c]) < SLOTS[c]) begin
        wf = 1; ws = c;
      end
      c = (m_rrr + k) % 4;
      if (!rf && rd_req[c] && cfg_enable[c] && !soft_clr[c] && (ncom[c] - nrd[c]) > 0) begin
        rf = 1; rs = c;
      end
    end
    m_wg = '0; m_rg = '0;
    if (wtake) begin
      m_awv = wf;
      if (wf) begin
        m_awa = BASE[ws] + 32'((nwr[ws] % SLOTS[ws]) * 1024);
        m_awc = ws; nwr[ws]++; m_rrw = (ws + 1) % 4; m_wg[ws] = 1'b1;
      end
    end
    if (rtake) begin
      m_arv = rf;
      if (rf) begin
        m_ara = BASE[rs] + 32'((nrd[rs] % SLOTS[rs]) * 1024);
        m_arc = rs; nrd[rs]++; m_rrr = (rs + 1) % 4; m_rg[rs] = 1'b1;
      end
    end
    if (wr_done) begin
      c = int'(wr_done_ch);
      if (ncom[c] % SLOTS[c] == SLOTS[c] - 1) m_eob[c] = 1'b1;
      ncom[c]++;
    end
    if (rd_done) nfree[int'(rd_done_ch)]++;
    for (int k = 0; k < 4; k++) begin
      if (clear_eob[k]) m_eob[k] = 1'b0;
      if (soft_clr[k]) begin
        nwr[k] = 0; nfree[k] = 0; ncom[k] = 0; nrd[k] = 0; m_eob[k] = 1'b0;
      end
    end
  endtask

  task automatic compare_model();
    logic [63:0] ef;
    logic [3:0]  efull, eemp;
    ef = '0; efull = '0; eemp = '0;
    for (int c = 0; c < 4; c++) begin
      ef[c*16 +: 16] = 16'(nwr[c] - nfree[c]);
      efull[c] = (SLOTS[c] != 0) && ((nwr[c] - nfree[c]) == SLOTS[c]);
      eemp[c]  = (ncom[c] - nrd[c]) == 0;
    end
    chk_val("aw_valid", aw_desc_valid, m_awv);
    if (m_awv) begin
      chk_val("aw_addr", aw_desc_addr, m_awa);
      chk_val("aw_ch", aw_desc_ch, m_awc);
    end
    chk_val("ar_valid", ar_desc_valid, m_arv);
    if (m_arv) begin
      chk_val("ar_addr", ar_desc_addr, m_ara);
      chk_val("ar_ch", ar_desc_ch, m_arc);
    end
    chk_val("wr_gnt", wr_gnt, m_wg);
    chk_val("rd_gnt", rd_gnt, m_rg);
    chk_val("wr_drop", wr_drop, 1'b0);
    chk_val("ch_fill", ch_fill, ef);
    chk_val("ch_full", ch_full, efull);
    chk_val("ch_empty", ch_empty, eemp);
    chk_val("eob", eob, m_eob);
    chk_val("data_loss", data_loss, 4'h0);
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    @(negedge clk);
    if (model_on) compare_model();
  endtask

  task automatic idle_inputs();
    wr_req = '0; rd_req = '0; soft_clr = '0; clear_eob = '0;
    wr_done = 0; wr_done_ch = '0; rd_done = 0; rd_done_ch = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ng;
    for (int c = 0; c < 4; c++) begin
      cfg_base_addr[c*32 +: 32] = BASE[c];
      cfg_slots[c*16 +: 16]     = 16'(SLOTS[c]);
    end
    cfg_enable = '0; aw_desc_ready = 1; ar_desc_ready = 1;
    idle_inputs();
    d_cfg_base_addr = '0; d_cfg_base_addr[64 +: 32] = 32'h3000;
    d_cfg_slots = '0; d_cfg_slots[32 +: 16] = 16'd2;
    d_cfg_enable = 4'b0100; d_soft_clr = '0; d_wr_req = '0; d_rd_req = '0; d_clear_eob = '0;
    d_aw_ready = 1; d_ar_ready = 1; d_wr_done = 0; d_wr_done_ch = '0; d_rd_done = 0; d_rd_done_ch = '0;
    model_reset();

    #1 rst = 1;
    repeat (2) @(negedge clk);
    chk_val("rst_aw_valid", aw_desc_valid, 1'b0);
    chk_val("rst_ch_empty", ch_empty, 4'hF);
    chk_val("rst_ch_fill", ch_fill, 64'h0);
    chk_val("rst_gnt", {wr_gnt, rd_gnt, eob, data_loss}, 16'h0);
    rst = 0;
    model_on = 1;

    // Round-robin order with all channels requesting and READY high.
    cfg_enable = 4'hF; wr_req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_val("rr_order", wr_gnt, 4'b0001 << (k % 4));
    end
    wr_req = '0; step();
    soft_clr = 4'hF; step(); soft_clr = '0;
    wq.delete(); rq.delete();
    chk_val("softclr_fill", ch_fill, 64'h0);

    // Single ring: four writes fill it, the fifth request is held off.
    cfg_enable = 4'b0001; wr_req = 4'b0001; ng = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (wr_gnt[0]) begin
        chk_val("ch0_waddr", aw_desc_addr, 32'h1000 + 32'h400 * ng);
        ng++;
      end
    end
    chk_val("ch0_wr_count", ng, 4);
    chk_val("ch0_full", ch_full[0], 1'b1);
    wr_req = '0; step();

    for (int k = 0; k < 4; k++) begin
      wr_done = 1; wr_done_ch = 2'(wq.pop_front());
      step();
      wr_done = 0;
      chk_val("ch0_eob_step", eob[0], k == 3);
    end
    clear_eob = 4'b0001; step(); clear_eob = '0;
    chk_val("ch0_eob_clear", eob[0], 1'b0);

    rd_req = 4'b0001; ng = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (rd_gnt[0]) begin
        chk_val("ch0_raddr", ar_desc_addr, 32'h1000 + 32'h400 * ng);
        ng++;
      end
    end
    chk_val("ch0_rd_count", ng, 4);
    chk_val("ch0_empty", ch_empty[0], 1'b1);
    rd_req = '0; step();
    while (rq.size() > 0) begin
      rd_done = 1; rd_done_ch = 2'(rq.pop_front());
      step();
    end
    rd_done = 0;
    wr_req = 4'b0001; step(); wr_req = '0;
    chk_val("ch0_wrap_addr", aw_desc_addr, 32'h1000);
    step();

    // READY held low: descriptor stays put and no further grants.
    cfg_enable = 4'hF; aw_desc_ready = 0; wr_req = 4'b0010;
    step();
    chk_val("stall_first", {aw_desc_valid, aw_desc_addr}, {1'b1, 32'h8000});
    for (int k = 0; k < 10; k++) begin
      step();
      chk_val("stall_hold", {aw_desc_valid, aw_desc_ch, aw_desc_addr, wr_gnt}, {1'b1, 2'd1, 32'h8000, 4'h0});
    end
    aw_desc_ready = 1; step();
    chk_val("stall_resume", {wr_gnt, aw_desc_addr}, {4'b0010, 32'h8400});
    wr_req = '0; step();

    // Randomized traffic with legal DONE ordering.
    for (int k = 0; k < 1500; k++) begin
      wr_req = 4'($urandom); rd_req = 4'($urandom);
      cfg_enable = ($urandom % 8 == 0) ? 4'($urandom) : 4'hF;
      aw_desc_ready = ($urandom % 10) < 7;
      ar_desc_ready = ($urandom % 10) < 7;
      clear_eob = ($urandom % 16 == 0) ? 4'($urandom) : 4'h0;
      wr_done = 0; rd_done = 0;
      if (wq.size() > 0 && ($urandom % 3) != 0) begin
        wr_done = 1; wr_done_ch = 2'(wq.pop_front());
      end
      if (rq.size() > 0 && ($urandom % 3) != 0) begin
        rd_done = 1; rd_done_ch = 2'(rq.pop_front());
      end
      step();
    end

    // Reset while a write descriptor is pending.
    idle_inputs(); cfg_enable = 4'hF; aw_desc_ready = 1; ar_desc_ready = 1;
    repeat (3) step();
    soft_clr = 4'hF; step(); soft_clr = '0;
    wq.delete(); rq.delete();
    aw_desc_ready = 0; wr_req = 4'b0001;
    step();
    chk_val("pre_rst_valid", aw_desc_valid, 1'b1);
    #2 rst = 1;
    #1;
    chk_val("async_rst_valid", aw_desc_valid, 1'b0);
    chk_val("async_rst_empty", ch_empty, 4'hF);
    @(posedge clk); @(negedge clk);
    rst = 0;
    model_reset();
    aw_desc_ready = 1;
    step();
    chk_val("post_rst_addr", {aw_desc_valid, aw_desc_addr}, {1'b1, 32'h1000});
    idle_inputs(); step();

    // Drop mode: a full channel is granted with WR_DROP and no descriptor.
    d_wr_req = 4'b0100;
    step();
    chk_val("drop_g1", {d_wr_gnt, d_wr_drop, d_aw_valid, d_aw_addr}, {4'b0100, 1'b0, 1'b1, 32'h3000});
    step();
    chk_val("drop_g2", {d_aw_addr, d_ch_full}, {32'h3400, 4'b0100});
    step();
    chk_val("drop_g3", {d_wr_gnt, d_wr_drop, d_aw_valid, d_data_loss}, {4'b0100, 1'b1, 1'b0, 4'b0100});
    d_wr_req = '0;
    step();
    chk_val("drop_after", {d_wr_gnt, d_wr_drop, d_data_loss}, {4'h0, 1'b0, 4'b0100});
    chk_val("drop_fill", d_ch_fill[32 +: 16], 16'd2);
    repeat (3) step();
    chk_val("drop_sticky", d_data_loss, 4'b0100);
    d_soft_clr = 4'b0100; step(); d_soft_clr = '0;
    chk_val("drop_softclr", {d_data_loss, d_ch_fill[32 +: 16]}, {4'h0, 16'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
